// File: rtl/seg_pkg.sv
// Shared character codes, segment patterns and code->pattern decode for the 7-seg display.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned CHAR_W = 5;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIGITS = 4;

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_ON   = 1'b1
  } phase_t;

  localparam logic [CHAR_W-1:0] C_HYPHEN = 5'd10;
  localparam logic [CHAR_W-1:0] C_E      = 5'd11;
  localparam logic [CHAR_W-1:0] C_r      = 5'd12;
  localparam logic [CHAR_W-1:0] C_L      = 5'd13;
  localparam logic [CHAR_W-1:0] C_b      = 5'd18;
  localparam logic [CHAR_W-1:0] C_d      = 5'd19;
  localparam logic [CHAR_W-1:0] C_BLANK  = 5'd31;

  localparam logic [SEG_W-1:0] P_0      = 7'b1000000;
  localparam logic [SEG_W-1:0] P_1      = 7'b1111001;
  localparam logic [SEG_W-1:0] P_2      = 7'b0100100;
  localparam logic [SEG_W-1:0] P_3      = 7'b0110000;
  localparam logic [SEG_W-1:0] P_4      = 7'b0011001;
  localparam logic [SEG_W-1:0] P_5      = 7'b0010010;
  localparam logic [SEG_W-1:0] P_6      = 7'b0000010;
  localparam logic [SEG_W-1:0] P_7      = 7'b1111000;
  localparam logic [SEG_W-1:0] P_8      = 7'b0000000;
  localparam logic [SEG_W-1:0] P_9      = 7'b0010000;
  localparam logic [SEG_W-1:0] P_HYPHEN = 7'b0111111;
  localparam logic [SEG_W-1:0] P_E      = 7'b0000110;
  localparam logic [SEG_W-1:0] P_R      = 7'b0101111;
  localparam logic [SEG_W-1:0] P_L      = 7'b1000111;
  localparam logic [SEG_W-1:0] P_B      = 7'b0000011;
  localparam logic [SEG_W-1:0] P_D      = 7'b0100001;
  localparam logic [SEG_W-1:0] P_BLANK  = 7'b1111111;

  // Unmapped codes render blank
  function automatic logic [SEG_W-1:0] seg_decode(input logic [CHAR_W-1:0] code);
    logic [SEG_W-1:0] pat;
    pat = P_BLANK;
    case (code)
      5'd0:     pat = P_0;
      5'd1:     pat = P_1;
      5'd2:     pat = P_2;
      5'd3:     pat = P_3;
      5'd4:     pat = P_4;
      5'd5:     pat = P_5;
      5'd6:     pat = P_6;
      5'd7:     pat = P_7;
      5'd8:     pat = P_8;
      5'd9:     pat = P_9;
      C_HYPHEN: pat = P_HYPHEN;
      C_E:      pat = P_E;
      C_r:      pat = P_R;
      C_L:      pat = P_L;
      C_b:      pat = P_B;
      C_d:      pat = P_D;
      default:  pat = P_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_char_decoder.sv
// Combinational 5-bit character code to active-low 7-segment pattern.
module seg_char_decoder
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] pattern_c
);

  assign pattern_c = seg_decode(code);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode 7-seg scanner with per-slot dead time and per-frame input snapshot.
// Optional macro SEG_DIM_EN adds a 3-bit `bright` input that shortens the lit part of each slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned DEAD_CYC = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] seg_data,
  input  logic [3:0]  dp_data,
`ifdef SEG_DIM_EN
  input  logic [2:0]  bright,
`endif
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam int unsigned ON_CYC   = SLOT_CYC - DEAD_CYC;
  localparam int unsigned CW       = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

  // The 1-cycle seg lag must land inside a non-empty dead interval
  if (!(DEAD_CYC >= 1 && DEAD_CYC + 1 < SLOT_CYC)) begin : g_param_check
    $error("seg_scan_driver: requires 1 <= DEAD_CYC and DEAD_CYC+1 < SLOT_CYC");
  end

  phase_t          phase;
  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [19:0]     sh_chars;
  logic [3:0]      sh_dp;
  logic [4:0]      cur_code;
  logic [6:0]      cur_pat_c;
  logic            on_nxt;
  logic            lit_nxt;
  logic [CW-1:0]   on_cnt_nxt;
  logic [31:0]     lit_cyc;

`ifdef SEG_DIM_EN
  logic [2:0]      sh_bright;
  assign lit_cyc = ((32'(sh_bright) + 32'd1) * 32'(ON_CYC)) >> 3;
`else
  assign lit_cyc = 32'(ON_CYC);
`endif

  always_comb begin
    cur_code = sh_chars[4:0];
    case (idx)
      2'd0: cur_code = sh_chars[4:0];
      2'd1: cur_code = sh_chars[9:5];
      2'd2: cur_code = sh_chars[14:10];
      2'd3: cur_code = sh_chars[19:15];
    endcase
  end

  seg_char_decoder u_dec (
    .code      (cur_code),
    .pattern_c (cur_pat_c)
  );

  // Anode/dp are registered from the next-cycle phase so they align exactly with it
  assign on_nxt     = (phase == PH_DEAD) ? (cnt == DEAD_LAST) : (cnt != SLOT_LAST);
  assign on_cnt_nxt = cnt - DEAD_LAST;
  assign lit_nxt    = on_nxt && (32'(on_cnt_nxt) < lit_cyc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= PH_DEAD;
      cnt      <= '0;
      idx      <= 2'd0;
      sh_chars <= {4{C_BLANK}};
      sh_dp    <= 4'd0;
`ifdef SEG_DIM_EN
      sh_bright <= 3'd7;
`endif
      an       <= 4'b1111;
      seg      <= P_BLANK;
      dp       <= 1'b1;
    end else begin
      cnt <= (cnt == SLOT_LAST) ? '0 : cnt + CW'(1);
      case (phase)
        PH_DEAD: if (cnt == DEAD_LAST) phase <= PH_ON;
        PH_ON: begin
          if (cnt == SLOT_LAST) begin
            phase <= PH_DEAD;
            idx   <= idx + 2'd1;
          end
        end
      endcase
      // Frame snapshot on the first cycle of digit 0's dead interval
      if (phase == PH_DEAD && cnt == '0 && idx == 2'd0) begin
        sh_chars <= seg_data;
        sh_dp    <= dp_data;
`ifdef SEG_DIM_EN
        sh_bright <= bright;
`endif
      end
      seg <= cur_pat_c;
      an  <= lit_nxt ? ~(4'b0001 << idx) : 4'b1111;
      dp  <= lit_nxt ? ~sh_dp[idx] : 1'b1;
    end
  end

endmodule
